dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Two-master round-robin arbiter in front of the single-port 4 KB data memory (dm_4k).
//   Masters are the CPU load/store port (m0) and a secondary port (m1, DMA/debug loader).
//   Grants one owner at a time, muxes address/data/write-enable to the memory port, fans read data back.
//   Bounds consecutive beats per owner so neither master starves.
// PARAMETERS
//   ADDR_W     32  width of master and memory address buses (byte address; memory uses [11:2])
//   DATA_W     32  width of write/read data
//   MAX_BURST  4   max consecutive beats for one owner while the other master is requesting (>=1)
// PORTS
//   clk        in   1       clock; memory writes and state updates on posedge
//   rst        in   1       asynchronous, active-high reset
//   m0_req     in   1       m0 access request; held with m0_we/addr/wdata until m0_ack
//   m0_we      in   1       m0 write (1) / read (0)
//   m0_addr    in   ADDR_W  m0 byte address
//   m0_wdata   in   DATA_W  m0 write data
//   m0_rdata   out  DATA_W  read data; valid only in a cycle with m0_ack=1
//   m0_ack     out  1       m0 beat completes this cycle
//   m1_*       --   --      identical set for master 1 (m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack)
//   mem_addr   out  ADDR_W  to dm DataAddr
//   mem_wdata  out  DATA_W  to dm WriteData
//   mem_we     out  1       to dm MemWrite
//   mem_rdata  in   DATA_W  from dm ReadData (combinational read)
// BEHAVIOUR
//   - States: IDLE, OWN0, OWN1 (registered). Registers: state, last (last owner), cnt (beat counter).
//   - Reset (async, immediate): state=IDLE, last=1 (m0 wins first tie), cnt=0.
//     Memory contents are untouched.
//   - Outputs (combinational from state + owner inputs):
//     - IDLE: m0_ack=m1_ack=0, mem_we=0, mem_addr=0, mem_wdata=0.
//     - OWNx: mem_addr=mx_addr, mem_wdata=mx_wdata, mem_we=mx_req&mx_we, mx_ack=mx_req, other ack=0.
//     - m0_rdata=m1_rdata=mem_rdata always; masters sample only on ack.
//   - Latency: a request from IDLE is acked on the next cycle.
//     Back-to-back beats by the owner are acked every cycle.
//   - IDLE transitions: no req -> stay. One req -> OWN of that master.
//     Both -> OWN of master != last.
//   - OWNx transitions (at posedge, cnt counts beats completed this ownership):
//     - mx_req & (!my_req | cnt < MAX_BURST-1) -> stay; cnt=cnt+1, saturating at MAX_BURST-1.
//     - else if my_req -> OWNy; cnt=0; last=x.
//     - else (mx_req=0, my_req=0) -> IDLE; cnt=0; last=x.
//   - Owner drops req while in OWNx: no ack, mem_we=0 that cycle. The transition rules above still apply.
//   - Non-owner request never receives ack, never drives memory.
//     It must hold req stable; it is served within MAX_BURST+1 cycles.
//   - Write commits at the posedge ending the ack cycle. A read returns the word at addr[11:2] in the ack cycle.
//   - rst asserted mid-beat: acks and mem_we fall to 0 without waiting for clk. The in-flight write is not committed.
//   - MAX_BURST=1 gives strict alternation under contention.
// TESTING
//   1. m0 write addr 0x10 data 0xDEADBEEF (req cycle 1) -> m0_ack=1 and mem_we=1 in cycle 2 only.
//      Then m1 read 0x10 -> m1_ack next cycle, m1_rdata=0xDEADBEEF.
//   2. After reset, m0_req=m1_req=1 continuously, MAX_BURST=4 -> acks m0 x4, m1 x4, m0 x4...
//      No idle gap between owners.
//   3. m1_req alone held 10 cycles -> one-cycle initial gap, then m1_ack high 10 consecutive cycles.
//      No forced switch.
//   4. m0 owner drops req mid-burst, m1 idle -> m0_ack=0, mem_we=0 that cycle.
//      State returns to IDLE; next m0 req is acked one cycle later.
//   5. rst pulsed (no clk edge) during m0 write beat -> m0_ack and mem_we drop immediately.
//      The target word keeps its old value. After release, a tie is granted to m0.
//   6. m0 single beat, then both request simultaneously -> m1 granted first (round robin, last=0).

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data memory.
// Grants one owner at a time and bounds its burst length while the other master waits.
module dm_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             own_req, oth_req, own_id;

  // Read data is a plain fan-out; masters only sample it while acked.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    own_req   = 1'b0;
    oth_req   = 1'b0;
    own_id    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // On a tie the master that did not own last time wins.
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        own_id    = 1'b0;
        own_req   = m0_req;
        oth_req   = m1_req;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = m0_req & m0_we;
        m0_ack    = m0_req;
      end
      OWN1: begin
        own_id    = 1'b1;
        own_req   = m1_req;
        oth_req   = m0_req;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_we    = m1_req & m1_we;
        m1_ack    = m1_req;
      end
      default: state_nxt = IDLE;
    endcase

    // Owner keeps the port until it stops asking or its burst budget runs out under contention.
    if (state != IDLE) begin
      if (own_req && (!oth_req || (cnt < CNT_MAX))) begin
        if (cnt < CNT_MAX) cnt_nxt = CNT_W'(cnt + 1'b1);
      end else begin
        cnt_nxt   = '0;
        last_nxt  = own_id;
        state_nxt = oth_req ? (own_id ? OWN0 : OWN1) : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized and directed bench for dm_arbiter with a behavioural grant/memory reference model.
module tb_dm_arbiter;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             req, we, ack;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata, rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata, mem_rdata;
  logic                   mem_we;

  logic [DATA_W-1:0] ram    [1024];
  logic [DATA_W-1:0] sb_mem [1024];

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 none), beats completed this ownership, last owner.
  int own, beats, last;
  logic [1:0]        obs_ack;
  logic              obs_we;
  logic [1:0][31:0]  obs_rd;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_rdata(rdata[0]), .m0_ack(ack[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_rdata(rdata[1]), .m1_ack(ack[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic void model_reset();
    own = -1; beats = 0; last = 1;
  endfunction

  function automatic void model_step();
    int o, y;
    if (own < 0) begin
      if (req[0] && req[1]) own = 1 - last;
      else if (req[0])      own = 0;
      else if (req[1])      own = 1;
      beats = 0;
    end else begin
      o = own; y = 1 - own;
      if (req[o] && (!req[y] || beats < int'(MAX_BURST) - 1)) beats++;
      else begin
        last = o; beats = 0;
        own = req[y] ? y : -1;
      end
    end
  endfunction

  // One clock cycle: check outputs at negedge against the model, then advance at posedge.
  task automatic tick();
    logic [1:0]  ea;
    logic        ew;
    logic [31:0] eaddr, ewd;
    @(negedge clk);
    ea[0] = (own == 0) && req[0];
    ea[1] = (own == 1) && req[1];
    ew = 1'b0; eaddr = '0; ewd = '0;
    if (own >= 0) begin
      eaddr = addr[own]; ewd = wdata[own]; ew = req[own] && we[own];
    end
    checks++;
    if (ack !== ea) begin errors++; $display("FAIL model_ack got %b exp %b t=%0t", ack, ea, $time); end
    checks++;
    if (mem_we !== ew) begin errors++; $display("FAIL model_mem_we got %b exp %b t=%0t", mem_we, ew, $time); end
    checks++;
    if (mem_addr !== eaddr) begin errors++; $display("FAIL model_mem_addr got %h exp %h t=%0t", mem_addr, eaddr, $time); end
    checks++;
    if (mem_wdata !== ewd) begin errors++; $display("FAIL model_mem_wdata got %h exp %h t=%0t", mem_wdata, ewd, $time); end
    for (int i = 0; i < 2; i++) begin
      if (ea[i] && !we[i]) begin
        checks++;
        if (rdata[i] !== sb_mem[addr[i][11:2]]) begin
          errors++;
          $display("FAIL model_rdata m%0d got %h exp %h t=%0t", i, rdata[i], sb_mem[addr[i][11:2]], $time);
        end
      end
    end
    obs_ack = ack; obs_we = mem_we; obs_rd = rdata;
    @(posedge clk);
    if (ew) sb_mem[eaddr[11:2]] = ewd;
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_ack(input string name, input logic [1:0] exp);
    checks++;
    if (obs_ack !== exp) begin errors++; $display("FAIL %s ack got %b exp %b", name, obs_ack, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; we = 2'b11;
    addr[0] = 32'h44; addr[1] = 32'h88; wdata[0] = 32'h1234; wdata[1] = 32'h5678;
    #2;
    checks++;
    if (ack !== 2'b00 || mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_ack ack %b we %b exp 00 0", ack, mem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || ack !== 2'b00) begin
      errors++; $display("FAIL reset_bus addr %h wdata %h ack %b exp 0 0 00", mem_addr, mem_wdata, ack);
    end
    req = '0; we = '0; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    req[0] = 1; we[0] = 1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    tick(); chk_ack("wr_idle", 2'b00);
    tick(); chk_ack("wr_beat", 2'b01);
    checks++;
    if (obs_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b exp 1", obs_we); end
    req[0] = 0; req[1] = 1; we[1] = 0; addr[1] = 32'h10;
    tick(); chk_ack("rd_wait", 2'b00);
    checks++;
    if (obs_we !== 1'b0) begin errors++; $display("FAIL wr_we_once got %b exp 0", obs_we); end
    tick(); chk_ack("rd_beat", 2'b10);
    checks++;
    if (obs_rd[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", obs_rd[1]); end
    req = '0; tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 32'h40; addr[1] = 32'h80;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 0) exp = 2'b00;
      else exp = (((k - 1) / int'(MAX_BURST)) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (obs_ack !== exp) begin errors++; $display("FAIL contention k=%0d ack %b exp %b", k, obs_ack, exp); end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_single();
    int acks = 0;
    do_reset();
    req[1] = 1; we[1] = 0; addr[1] = 32'h24;
    tick(); chk_ack("single_gap", 2'b00);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_ack == 2'b10) acks++;
    end
    checks++;
    if (acks != 10) begin errors++; $display("FAIL single_run acks %0d exp 10", acks); end
    req = '0; tick();
  endtask

  task automatic test_drop();
    do_reset();
    req[0] = 1; we[0] = 1; addr[0] = 32'h30; wdata[0] = $urandom;
    tick(); chk_ack("drop_idle", 2'b00);
    tick(); chk_ack("drop_b1", 2'b01);
    wdata[0] = $urandom;
    tick(); chk_ack("drop_b2", 2'b01);
    req[0] = 0;
    tick(); chk_ack("drop_cycle", 2'b00);
    checks++;
    if (obs_we !== 1'b0) begin errors++; $display("FAIL drop_we got %b exp 0", obs_we); end
    req[0] = 1; wdata[0] = $urandom;
    tick(); chk_ack("drop_reidle", 2'b00);
    tick(); chk_ack("drop_regrant", 2'b01);
    req = '0; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[0] = 1; we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h11112222;
    tick(); tick(); req[0] = 0; tick();
    req[0] = 1; wdata[0] = 32'h33334444;
    tick();
    #1;
    checks++;
    if (ack !== 2'b01 || mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre ack %b we %b exp 01 1", ack, mem_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_drop ack %b we %b exp 00 0", ack, mem_we); end
    req[0] = 0;
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); model_step(); #1;
    req = 2'b11; we = 2'b00; addr[0] = 32'h20; addr[1] = 32'h20;
    tick(); chk_ack("rstmid_idle", 2'b00);
    tick(); chk_ack("rstmid_tie", 2'b01);
    checks++;
    if (obs_rd[0] !== 32'h11112222) begin errors++; $display("FAIL rstmid_keep got %h exp 11112222", obs_rd[0]); end
    req[0] = 0;
    tick(); chk_ack("rstmid_switch", 2'b00);
    tick(); chk_ack("rstmid_m1", 2'b10);
    req = '0; tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req[0] = 1; we[0] = 1; addr[0] = 32'h50; wdata[0] = 32'hCAFEF00D;
    tick(); tick(); chk_ack("rr_m0", 2'b01);
    req = '0;
    tick();
    req = 2'b11; we = 2'b00; addr[0] = 32'h50; addr[1] = 32'h54;
    tick(); chk_ack("rr_idle", 2'b00);
    tick(); chk_ack("rr_m1_first", 2'b10);
    req = '0; tick(); tick();
  endtask

  task automatic test_random();
    int wait_c [2];
    logic [1:0] pend;
    do_reset();
    pend = '0; wait_c[0] = 0; wait_c[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
          pend[i] = 1'b1;
          we[i] = 1'($urandom_range(0, 1));
          addr[i] = $urandom & 32'hFFF0_00FF;
          wdata[i] = $urandom;
        end
      end
      req = pend;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && obs_ack[i]) begin
          checks++;
          if (wait_c[i] > int'(MAX_BURST) + 1) begin
            errors++; $display("FAIL starve m%0d waited %0d max %0d", i, wait_c[i], MAX_BURST + 1);
          end
          wait_c[i] = 0;
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          wait_c[i]++;
          if (wait_c[i] > 50) begin
            checks++; errors++;
            $display("FAIL starve_timeout m%0d waited %0d", i, wait_c[i]);
            pend[i] = 1'b0; wait_c[i] = 0;
          end
        end
      end
    end
    req = '0; tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      sb_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_contention();
    test_single();
    test_drop();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
